// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver: glyph table, blank pattern
// and segment bit positions of the active-low {dp,g,f,e,d,c,b,a} byte.
package seg_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Active-low g..a patterns; element 15 first in the concatenation.
   localparam logic [15:0][6:0] SEG_HEX = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Host-side bundle of the scan driver: display content in, pin drive out.
interface seg_scan_driver_if #(
   parameter int N_DIGITS = 8
);
   logic [4*N_DIGITS-1:0] data;
   logic [8*N_DIGITS-1:0] raw;
   logic [N_DIGITS-1:0]   raw_en;
   logic [N_DIGITS-1:0]   le;
   logic [N_DIGITS-1:0]   point;
   logic [N_DIGITS-1:0]   blink;
   logic [3:0]            bright;
   logic [7:0]            seg;
   logic [N_DIGITS-1:0]   an;
   logic                  frame;

   modport master (
      output data, raw, raw_en, le, point, blink, bright,
      input  seg, an, frame
   );

   modport slave (
      input  data, raw, raw_en, le, point, blink, bright,
      output seg, an, frame
   );
endinterface

// File: rtl/seg_scan_driver_hex_glyph.sv
// Hex nibble plus decimal-point request to an active-low segment byte.
module seg_hex_glyph
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       point,
   output logic [7:0] seg
);

   assign seg = {~point, SEG_HEX[nibble]};

endmodule

// File: rtl/seg_scan_driver.sv
// Self-scanning multi-digit common-anode 7-segment driver with per-frame
// shadow registers, per-digit blink, PWM brightness and hex/raw mode.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int N_DIGITS   = 8,
   parameter int DIV_LOG2   = 17,
   parameter int BLINK_LOG2 = 5
) (
   input logic               clk,
   input logic               rst,
   seg_scan_driver_if.slave  bus
);

   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

   logic [DIV_LOG2-1:0]   cnt;
   logic [IDX_W-1:0]      idx;
   logic                  tick;
   logic                  load;

   logic [3:0]            data_sh [N_DIGITS];
   logic [7:0]            raw_sh  [N_DIGITS];
   logic [N_DIGITS-1:0]   raw_en_sh;
   logic [N_DIGITS-1:0]   le_sh;
   logic [N_DIGITS-1:0]   point_sh;
   logic [N_DIGITS-1:0]   blink_sh;
   logic [3:0]            bright_sh;

   logic [BLINK_LOG2-1:0] frame_cnt;
   logic                  phase;

   logic                  on;
   logic                  visible;
   logic [7:0]            hex_seg;
   logic [7:0]            seg_nx;
   logic [N_DIGITS-1:0]   an_nx;

   assign tick = &cnt;
   assign load = tick && (idx == IDX_LAST);

   // Free-running prescaler and digit index; index steps once per slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         cnt <= cnt + 1'b1;
         if (tick)
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
   end

   // Capture display content once per frame so a digit never shows a mix of
   // old and new host data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            data_sh[i] <= '0;
            raw_sh[i]  <= '0;
         end
         raw_en_sh <= '0;
         le_sh     <= '0;
         point_sh  <= '0;
         blink_sh  <= '0;
         bright_sh <= '0;
      end else if (load) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            data_sh[i] <= bus.data[4*i +: 4];
            raw_sh[i]  <= bus.raw[8*i +: 8];
         end
         raw_en_sh <= bus.raw_en;
         le_sh     <= bus.le;
         point_sh  <= bus.point;
         blink_sh  <= bus.blink;
         bright_sh <= bus.bright;
      end
   end

   // Frame counter for blinking; phase flips each time the counter wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
         phase     <= 1'b0;
      end else if (load) begin
         frame_cnt <= frame_cnt + 1'b1;
         if (&frame_cnt)
            phase <= ~phase;
      end
   end

   seg_hex_glyph u_glyph (
      .nibble (data_sh[idx]),
      .point  (point_sh[idx]),
      .seg    (hex_seg)
   );

   assign on      = cnt[DIV_LOG2-1 -: 4] <= bright_sh;
   assign visible = le_sh[idx] & on & ~(blink_sh[idx] & phase);
   assign seg_nx  = raw_en_sh[idx] ? raw_sh[idx] : hex_seg;
   assign an_nx   = ~(N_DIGITS'(1) << idx);

   // Registered pin drive: seg and an switch on the same edge, so no ghosting
   // between adjacent digits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.seg   <= SEG_OFF;
         bus.an    <= '1;
         bus.frame <= 1'b0;
      end else begin
         bus.frame <= load;
         if (visible) begin
            bus.seg <= seg_nx;
            bus.an  <= an_nx;
         end else begin
            bus.seg <= SEG_OFF;
            bus.an  <= '1;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with 16-cycle slots and a 2-frame
// blink half-period.
module tb_seg_scan_driver;

   localparam int N  = 8;
   localparam int DL = 4;
   localparam int BL = 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] exp_q [$];

   seg_scan_driver_if #(.N_DIGITS(N)) bus ();

   seg_scan_driver #(.N_DIGITS(N), .DIV_LOG2(DL), .BLINK_LOG2(BL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] ref_glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h18;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   // Waits for the next frame pulse, sampled on the falling edge.
   task automatic wait_frame();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.frame !== 1'b1 && n < 400);
      if (bus.frame !== 1'b1) begin
         errors++;
         $display("FAIL frame_timeout: no frame within %0d cycles", n);
      end
   endtask

   task automatic test_reset();
      int n;
      int lit;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.an, bus.seg, bus.frame} !== {8'hFF, 8'hFF, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: an=%h seg=%h frame=%b want an=ff seg=ff frame=0",
                  bus.an, bus.seg, bus.frame);
      end
      rst = 1'b0;
      n = 0;
      lit = 0;
      do begin
         @(negedge clk);
         n++;
         if (bus.an !== 8'hFF) lit++;
      end while (bus.frame !== 1'b1 && n < 400);
      checks++;
      if (n !== N * 16) begin
         errors++;
         $display("FAIL first_frame: got %0d cycles want %0d", n, N * 16);
      end
      checks++;
      if (lit !== 0) begin
         errors++;
         $display("FAIL dark_before_load: lit cycles %0d want 0", lit);
      end
   endtask

   task automatic test_hex();
      logic [31:0] d = 32'h0123_4567;
      logic [15:0] e;
      bus.data = d;
      wait_frame();
      for (int k = 0; k < N; k++)
         exp_q.push_back({~(8'(1) << k), 1'b1, ref_glyph(d[4*k +: 4])});
      for (int k = 0; k < N; k++) begin
         repeat ((k == 0) ? 9 : 16) @(posedge clk);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({bus.an, bus.seg} !== e) begin
            errors++;
            $display("FAIL hex_slot%0d: an=%h seg=%h want an=%h seg=%h",
                     k, bus.an, bus.seg, e[15:8], e[7:0]);
         end
      end
   endtask

   task automatic test_update();
      logic [31:0] d = 32'h0123_4567;
      logic [15:0] e;
      wait_frame();
      repeat (9 + 48) @(posedge clk);
      @(negedge clk);
      bus.data = 32'hFFFF_FFFF;
      for (int k = 3; k < N; k++)
         exp_q.push_back({~(8'(1) << k), 1'b1, ref_glyph(d[4*k +: 4])});
      for (int k = 3; k < N; k++) begin
         if (k != 3) begin
            repeat (16) @(posedge clk);
            @(negedge clk);
         end
         e = exp_q.pop_front();
         checks++;
         if ({bus.an, bus.seg} !== e) begin
            errors++;
            $display("FAIL update_hold_slot%0d: an=%h seg=%h want an=%h seg=%h",
                     k, bus.an, bus.seg, e[15:8], e[7:0]);
         end
      end
      wait_frame();
      for (int k = 0; k < N; k++)
         exp_q.push_back({~(8'(1) << k), 8'h8E});
      for (int k = 0; k < N; k++) begin
         repeat ((k == 0) ? 9 : 16) @(posedge clk);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({bus.an, bus.seg} !== e) begin
            errors++;
            $display("FAIL update_new_slot%0d: an=%h seg=%h want an=%h seg=%h",
                     k, bus.an, bus.seg, e[15:8], e[7:0]);
         end
      end
   endtask

   task automatic test_raw();
      logic [15:0] e;
      bus.data   = 32'h0123_4567;
      bus.raw    = {{7{8'hFF}}, 8'h55};
      bus.raw_en = 8'h01;
      bus.point  = 8'h02;
      wait_frame();
      exp_q.push_back({8'hFE, 8'h55});
      exp_q.push_back({8'hFD, 1'b0, ref_glyph(4'h6)});
      exp_q.push_back({8'hFB, 1'b1, ref_glyph(4'h5)});
      for (int k = 0; k < 3; k++) begin
         repeat ((k == 0) ? 9 : 16) @(posedge clk);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({bus.an, bus.seg} !== e) begin
            errors++;
            $display("FAIL raw_slot%0d: an=%h seg=%h want an=%h seg=%h",
                     k, bus.an, bus.seg, e[15:8], e[7:0]);
         end
      end
      bus.raw_en = '0;
      bus.point  = '0;
   endtask

   task automatic test_brightness();
      logic [3:0] lv [2] = '{4'd3, 4'd0};
      int on_cnt;
      int first_off;
      logic [15:0] e;
      for (int t = 0; t < 2; t++) begin
         bus.bright = lv[t];
         wait_frame();
         exp_q.push_back({8'(lv[t] + 1), 8'(lv[t] + 1)});
         on_cnt = 0;
         first_off = -1;
         for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (bus.an === 8'hFE) on_cnt++;
            else if (first_off < 0) first_off = c;
         end
         e = exp_q.pop_front();
         checks++;
         if ({8'(on_cnt), 8'(first_off)} !== e) begin
            errors++;
            $display("FAIL bright%0d: on=%0d first_off=%0d want on=%0d first_off=%0d",
                     lv[t], on_cnt, first_off, e[15:8], e[7:0]);
         end
      end
      bus.bright = 4'd15;
   endtask

   task automatic test_blink();
      logic ph;
      logic [15:0] e;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.blink = 8'h01;
      for (int f = 1; f <= 5; f++) begin
         wait_frame();
         ph = ((f / 2) % 2) == 1;
         exp_q.push_back(ph ? 16'hFFFF : {8'hFE, 1'b1, ref_glyph(4'h7)});
         exp_q.push_back({8'hFD, 1'b1, ref_glyph(4'h6)});
         for (int k = 0; k < 2; k++) begin
            repeat ((k == 0) ? 9 : 16) @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({bus.an, bus.seg} !== e) begin
               errors++;
               $display("FAIL blink_f%0d_slot%0d: an=%h seg=%h want an=%h seg=%h",
                        f, k, bus.an, bus.seg, e[15:8], e[7:0]);
            end
         end
      end
      bus.blink = '0;
   endtask

   task automatic test_reset_mid();
      int n;
      int lit;
      wait_frame();
      repeat (20) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.an === 8'hFF) begin
         errors++;
         $display("FAIL pre_reset_lit: an=%h want a digit lit", bus.an);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.an, bus.seg} !== 16'hFFFF) begin
         errors++;
         $display("FAIL reset_async: an=%h seg=%h want an=ff seg=ff", bus.an, bus.seg);
      end
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      lit = 0;
      do begin
         @(negedge clk);
         n++;
         if (bus.an !== 8'hFF || bus.seg !== 8'hFF) lit++;
      end while (bus.frame !== 1'b1 && n < 400);
      checks++;
      if (n !== N * 16) begin
         errors++;
         $display("FAIL reset_mid_frame: got %0d cycles want %0d", n, N * 16);
      end
      checks++;
      if (lit !== 0) begin
         errors++;
         $display("FAIL reset_mid_dark: lit cycles %0d want 0", lit);
      end
      repeat (9) @(posedge clk);
      @(negedge clk);
      exp_q.push_back({8'hFE, 1'b1, ref_glyph(4'h7)});
      e_check_restart: begin
         logic [15:0] e;
         e = exp_q.pop_front();
         checks++;
         if ({bus.an, bus.seg} !== e) begin
            errors++;
            $display("FAIL restart_slot0: an=%h seg=%h want an=%h seg=%h",
                     bus.an, bus.seg, e[15:8], e[7:0]);
         end
      end
   endtask

   initial begin
      bus.data   = 32'h0123_4567;
      bus.raw    = '0;
      bus.raw_en = '0;
      bus.le     = 8'hFF;
      bus.point  = '0;
      bus.blink  = '0;
      bus.bright = 4'd15;
      #2;
      test_reset();
      test_hex();
      test_update();
      bus.data = 32'h0123_4567;
      test_raw();
      test_brightness();
      test_blink();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised, self-scanning multi-digit 7-segment driver for the board's common-anode display, successor to the purely combinational segment decoder. Owns its scan prescaler and digit index, latches display content into shadow registers once per frame (tear-free update with a frame pulse to the host), and adds per-digit blink, global PWM brightness and a hex/raw mode per digit. Sits between the top-level data mux and the `seg`/`an` pins.

## Interface
- `N_DIGITS`, 8: number of digits scanned, 1..8.
- `DIV_LOG2`, 17: each digit slot lasts 2^DIV_LOG2 clocks; must be ≥ 4.
- `BLINK_LOG2`, 5: blink phase toggles every 2^BLINK_LOG2 frames.
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `data` in 4*N_DIGITS: hex nibbles, digit i = `data[4i+3:4i]`, digit 0 rightmost.
- `raw` in 8*N_DIGITS: raw active-low segment bytes, digit i = `raw[8i+7:8i]` ({dp,g,f,e,d,c,b,a}).
- `raw_en` in N_DIGITS: per digit, 1 = show `raw` byte, 0 = hex glyph of `data` nibble.
- `le` in N_DIGITS: digit enable; 0 = digit dark.
- `point` in N_DIGITS: decimal point on (hex mode only).
- `blink` in N_DIGITS: digit blanked during blink phase 1.
- `bright` in 4: duty level, 0 = 1/16 … 15 = 16/16.
- `seg` out 8: active-low {dp,g..a}.
- `an` out N_DIGITS: active-low anodes, at most one low.
- `frame` out 1: one-cycle pulse when shadow registers load.

## Operation
- Prescaler `cnt` (DIV_LOG2 bits) free-runs; `tick` = `cnt` all-ones.
- Digit index `idx` advances on `tick`, wraps N_DIGITS-1 → 0.
- Shadow load: on `tick` with `idx` = N_DIGITS-1, all of `data`, `raw`, `raw_en`, `le`, `point`, `blink` are captured; `bright` is captured in the same cycle. `frame` asserts in the cycle after that edge (the first cycle of digit 0). Inputs between loads are ignored.
- Blink: frame counter (BLINK_LOG2 bits) increments on each shadow load; `phase` toggles when it wraps.
- Duty: `on` = `cnt[DIV_LOG2-1 -: 4]` ≤ shadow `bright`.
- Digit visible = shadow `le[idx]` & `on` & ~(shadow `blink[idx]` & `phase`).
- Visible: `an` = one-cold at bit `idx`; `seg` = raw byte if `raw_en[idx]`, else {~point[idx], glyph(nibble)}. Not visible: `an` all ones, `seg` = 8'hFF.
- Glyph table, active-low g..a: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=18 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
- Simultaneous input change and shadow load: the value present at the load edge wins.
- N_DIGITS < 8: unused high digits do not exist; `idx` never exceeds N_DIGITS-1.

## Timing
- Reset (async assert, sync release): `cnt`=0, `idx`=0, shadows=0, blink counter=0, `phase`=0, `seg`=8'hFF, `an` all ones, `frame`=0. Display stays dark until first shadow load (`le` shadow = 0).
- First `frame` pulse: N_DIGITS·2^DIV_LOG2 cycles after reset release.
- `seg`/`an` are registered: they reflect `idx`/`cnt` state of the previous cycle (1-cycle latency); no glitch between digits since both switch on the same edge.
- Reset mid-frame: outputs dark immediately (asynchronous); scan restarts at digit 0.
- Frame period N_DIGITS·2^DIV_LOG2; blink half-period 2^BLINK_LOG2 frames.

## Structure
- Package `seg_pkg`: glyph table constant `SEG_HEX[16]`, blank constant `SEG_OFF` = 8'hFF, segment-bit index constants.
- One sub-module `seg_hex_glyph` (nibble + dp → 8-bit active-low pattern, combinational). Everything else flat.

## Test plan
- DIV_LOG2=4, N_DIGITS=8, `le`=FF, `bright`=15, `data`=32'h0123_4567 → after first `frame`, slot idx 0 shows `an`=FE, `seg`=8'hF8; idx 7 shows `an`=7F, `seg`=8'hC0; each slot 16 cycles.
- Change `data` mid-frame to 32'hFFFF_FFFF → outputs unchanged until next `frame`; then all digits `seg`=8'h8E.
- `raw_en`=01, `raw[7:0]`=8'h55, `point`=02 → digit 0 `seg`=8'h55; digit 1 dp bit 0.
- `bright`=3 → `an` low for exactly 4 of each 16 cycles of a slot; `bright`=0 → 1 of 16.
- BLINK_LOG2=1, `blink`=01 → digit 0 dark on alternate 2-frame periods, other digits continuous.
- Assert `rst` mid-slot for 1 cycle → `seg`=FF, `an`=FF same cycle; next `frame` exactly 8·16 cycles after release, all digits dark until then.
